// File: rtl/codec_config_seq.sv
// codec_config_seq: walks the WM8731 bring-up register table after reset and
// issues one 24-bit write frame per entry to the upstream I2C controller.
// Each attempt is start -> wait done low -> wait done high (bounded by a
// timeout) -> ack check. A programmable idle gap follows every finished entry.
// Optional feature macro: CODEC_CFG_RETRY_EN (relaunch a failed entry up to
// MAX_RETRIES extra times before flagging cfg_error).
module codec_config_seq #(
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  output logic [23:0] i2c_data,
  output logic        start,
  input  logic        done,
  input  logic        ack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  cfg_index
);

  localparam int         NUM_ENTRIES = 11;
  localparam logic [3:0] LAST_INDEX  = 4'd10;

  // {reg[6:0], val[8:0]} for each bring-up write, in issue order
  localparam logic [15:0] ENTRY_TABLE [NUM_ENTRIES] = '{
    {7'd15, 9'h000},  // reset
    {7'd0,  9'h017},
    {7'd1,  9'h017},
    {7'd2,  9'h079},
    {7'd3,  9'h079},
    {7'd4,  9'h012},
    {7'd5,  9'h000},
    {7'd6,  9'h000},
    {7'd7,  9'h042},
    {7'd8,  9'h000},
    {7'd9,  9'h001}
  };

  typedef enum logic [3:0] {
    S_RESET, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI,
    S_CHECK, S_GAP, S_FINISH, S_IDLE
  } state_t;

  logic [23:0] frame_rom [NUM_ENTRIES];

  // Full frames with the device address prepended
  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_rom
      assign frame_rom[gi] = {DEV_ADDR, ENTRY_TABLE[gi]};
    end
  endgenerate

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [23:0] data_q, data_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        ok_q, ok_d;
  logic        cfg_done_q, cfg_done_d;
  logic        cfg_error_q, cfg_error_d;
`ifdef CODEC_CFG_RETRY_EN
  logic [31:0] retry_q, retry_d;
`endif

  logic timeout_hit;
  logic gap_over;

  // Timeout spans WAIT_LO and WAIT_HI together; the counter is cleared in START
  assign timeout_hit = (to_cnt_q >= TIMEOUT_CYCLES - 1);
  // GAP always occupies at least one cycle, so a zero gap still works
  assign gap_over    = (GAP_CYCLES == 0) || (gap_cnt_q >= GAP_CYCLES - 1);

  // Next-state, datapath and status-flag logic
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    data_d      = data_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    ok_d        = ok_q;
    cfg_done_d  = cfg_done_q;
    cfg_error_d = cfg_error_q;
`ifdef CODEC_CFG_RETRY_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      S_RESET: begin
        // frame is loaded on entry to LOAD so it is valid a cycle before start
        index_d = 4'd0;
        data_d  = frame_rom[0];
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        to_cnt_d = 32'd0;
        state_d  = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (!done) begin
          state_d = S_WAIT_HI;
        end else if (timeout_hit) begin
          ok_d    = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_WAIT_HI: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (done) begin
          ok_d    = ack;  // ack is only meaningful while done is high
          state_d = S_CHECK;
        end else if (timeout_hit) begin
          ok_d    = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        gap_cnt_d = 32'd0;
        if (ok_q) begin
          state_d = S_GAP;
        end else begin
`ifdef CODEC_CFG_RETRY_EN
          if (retry_q < MAX_RETRIES) begin
            retry_d = retry_q + 32'd1;
            state_d = S_LOAD;  // same entry, frame already held in data_q
          end else begin
            cfg_error_d = 1'b1;
            state_d     = S_GAP;
          end
`else
          cfg_error_d = 1'b1;
          state_d     = S_GAP;
`endif
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 32'd1;
        if (gap_over) begin
          if (index_q == LAST_INDEX) begin
            state_d = S_FINISH;
          end else begin
            index_d = index_q + 4'd1;
            data_d  = frame_rom[index_q + 4'd1];
`ifdef CODEC_CFG_RETRY_EN
            retry_d = 32'd0;
`endif
            state_d = S_LOAD;
          end
        end
      end
      S_FINISH: begin
        cfg_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_IDLE: begin
        if (go) begin
          cfg_done_d  = 1'b0;
          cfg_error_d = 1'b0;
          index_d     = 4'd0;
          data_d      = frame_rom[0];
`ifdef CODEC_CFG_RETRY_EN
          retry_d     = 32'd0;
`endif
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESET;
      index_q     <= 4'd0;
      data_q      <= 24'd0;
      gap_cnt_q   <= 32'd0;
      to_cnt_q    <= 32'd0;
      ok_q        <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_error_q <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
      retry_q     <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      data_q      <= data_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
      ok_q        <= ok_d;
      cfg_done_q  <= cfg_done_d;
      cfg_error_q <= cfg_error_d;
`ifdef CODEC_CFG_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign i2c_data  = data_q;
  assign start     = (state_q == S_START);
  assign cfg_busy  = (state_q != S_IDLE);
  assign cfg_done  = cfg_done_q;
  assign cfg_error = cfg_error_q;
  assign cfg_index = index_q;

endmodule

// File: tb/tb_codec_config_seq.sv
// Bench for codec_config_seq: behavioural I2C controller stand-in plus a
// table/loop reference model of which frames must appear and whether the
// run ends in error. Works for both settings of CODEC_CFG_RETRY_EN.
module tb_codec_config_seq;
  localparam int GAP  = 4;
  localparam int TMO  = 64;
  localparam int MAXR = 3;
`ifdef CODEC_CFG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic go = 1'b0;
  logic done = 1'b0;
  logic ack = 1'b0;
  logic [23:0] i2c_data;
  logic start, cfg_busy, cfg_done, cfg_error;
  logic [3:0] cfg_index;

  codec_config_seq #(
    .DEV_ADDR(8'h34), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .i2c_data(i2c_data), .start(start),
    .done(done), .ack(ack), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .cfg_index(cfg_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register numbers and values of the bring-up table
  int reg_of [11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int val_of [11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h042, 'h000, 'h001};

  function automatic logic [23:0] model_frame(input int e);
    int v;
    v = ('h34 * 65536) + (reg_of[e] * 512) + val_of[e];
    return v[23:0];
  endfunction

  function automatic int lookup(input logic [23:0] f);
    for (int e = 0; e < 11; e++) if (model_frame(e) == f) return e;
    return -1;
  endfunction

  // Slave policy and observed traffic
  int nack_entry = -1;
  int nack_left  = 0;
  int hang_entry = -1;
  int lat_min = 2;
  int lat_max = 8;
  logic [23:0] frames[$];
  int start_cyc[$];
  logic [23:0] exp_frames[$];

  // Reference: per entry, attempts repeat while failing and retries remain
  function automatic bit build_expect(input int ne, input int nt, input int he);
    bit err, fin, fail;
    int left, tries;
    err = 0; left = nt;
    exp_frames.delete();
    for (int e = 0; e < 11; e++) begin
      tries = 0; fin = 0;
      while (!fin) begin
        exp_frames.push_back(model_frame(e));
        fail = (e == he) || (e == ne && left > 0);
        if (e == ne && left > 0) left--;
        if (!fail) fin = 1;
        else if (RETRY_EN && tries < MAXR) tries++;
        else begin err = 1; fin = 1; end
      end
    end
    return err;
  endfunction

  // Behavioural controller: drops done on start, raises it with ack later
  initial begin : slave
    int busy;
    bit active, hang, resp;
    logic [23:0] prev;
    int idx;
    busy = 0; active = 0; hang = 0; resp = 0; prev = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        done = 0; ack = 0; active = 0;
      end else begin
        if (active && !hang) begin
          busy--;
          if (busy <= 0) begin done = 1; ack = resp; active = 0; end
        end
        if (start) begin
          chk("data_before_start", i2c_data, prev);
          frames.push_back(i2c_data);
          start_cyc.push_back(cyc);
          idx = lookup(i2c_data);
          done = 0; ack = 0; active = 1;
          busy = $urandom_range(lat_max, lat_min);
          hang = (idx >= 0 && idx == hang_entry);
          resp = 1;
          if (idx >= 0 && idx == nack_entry && nack_left > 0) begin
            resp = 0; nack_left--;
          end
        end
      end
      prev = i2c_data;
    end
  end

  task automatic pulse_go();
    @(negedge clk); go = 1;
    @(negedge clk); go = 0;
  endtask

  task automatic run(input int id, input int ne, input int nt, input int he,
                     input int starts_exp, input bit err_exp, input bit use_table,
                     input bit via_go);
    bit merr;
    int n, p, first_bad;
    nack_entry = ne; nack_left = nt; hang_entry = he;
    frames.delete(); start_cyc.delete();
    merr = build_expect(ne, nt, he);
    if (via_go) begin
      pulse_go();
      chk($sformatf("s%0d_go_clears_done", id), cfg_done, 0);
      chk($sformatf("s%0d_go_clears_error", id), cfg_error, 0);
      chk($sformatf("s%0d_go_busy", id), cfg_busy, 1);
      chk($sformatf("s%0d_go_index", id), cfg_index, 0);
    end
    // go while busy must not restart the table
    repeat (20) @(negedge clk);
    go = 1; @(negedge clk); go = 0;
    n = 0;
    while (!(cfg_done && !cfg_busy) && n < 5000) begin @(negedge clk); n++; end
    chk($sformatf("s%0d_complete", id), cfg_done, 1);
    chk($sformatf("s%0d_idle", id), cfg_busy, 0);
    chk($sformatf("s%0d_index", id), cfg_index, 10);
    chk($sformatf("s%0d_error", id), cfg_error, merr);
    chk($sformatf("s%0d_frame_count", id), frames.size(), exp_frames.size());
    first_bad = -1;
    for (int i = 0; i < frames.size() && i < exp_frames.size(); i++)
      if (first_bad < 0 && frames[i] !== exp_frames[i]) first_bad = i;
    if (first_bad >= 0)
      chk($sformatf("s%0d_frame%0d", id, first_bad), frames[first_bad], exp_frames[first_bad]);
    else
      chk($sformatf("s%0d_frames", id), frames.size() > 0 ? frames[frames.size()-1] : 24'h0,
          exp_frames[exp_frames.size()-1]);
    if (use_table) begin
      chk($sformatf("s%0d_table_starts", id), frames.size(), starts_exp);
      chk($sformatf("s%0d_table_error", id), cfg_error, err_exp);
    end
    if (he >= 0) begin
      p = -1;
      for (int i = 0; i < frames.size(); i++) if (p < 0 && frames[i] == model_frame(he)) p = i;
      if (p >= 0 && p + 1 < start_cyc.size())
        chk($sformatf("s%0d_timeout_interval", id), start_cyc[p+1] - start_cyc[p],
            TMO + 3 + (RETRY_EN ? 0 : GAP));
      else
        chk($sformatf("s%0d_timeout_frame_found", id), p, 32'hFFFF_FFFF);
    end
  endtask

  typedef struct {
    int ne; int nt; int he; int starts; bit err;
  } scen_t;

  initial begin : main
    scen_t vec [4];
    int rel, n, ne, nt, he;
    vec[0] = '{-1, 0, -1, 11, 1'b0};
    vec[1] = '{3, 1, -1, RETRY_EN ? 12 : 11, RETRY_EN ? 1'b0 : 1'b1};
    vec[2] = '{5, 99, -1, RETRY_EN ? 14 : 11, 1'b1};
    vec[3] = '{-1, 0, 2, RETRY_EN ? 14 : 11, 1'b1};

    #2 reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_busy", cfg_busy, 1);
    chk("rst_done", cfg_done, 0);
    chk("rst_error", cfg_error, 0);
    chk("rst_index", cfg_index, 0);
    reset_n = 1;
    rel = cyc;
    run(0, vec[0].ne, vec[0].nt, vec[0].he, vec[0].starts, vec[0].err, 1, 0);
    chk("first_start_latency", start_cyc.size() > 0 ? start_cyc[0] - rel : -1, 2);

    for (int i = 1; i < 4; i++)
      run(i, vec[i].ne, vec[i].nt, vec[i].he, vec[i].starts, vec[i].err, 1, 1);

    // Reset pulsed during entry 4 WAIT_HI, then restart from entry 0
    lat_min = 10; lat_max = 10;
    nack_entry = -1; hang_entry = -1;
    frames.delete(); start_cyc.delete();
    pulse_go();
    n = 0;
    while (frames.size() < 5 && n < 2000) begin @(negedge clk); n++; end
    chk("midreset_reached_entry4", frames.size(), 5);
    repeat (3) @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("midreset_start", start, 0);
    chk("midreset_data", i2c_data, 0);
    chk("midreset_busy", cfg_busy, 1);
    chk("midreset_done", cfg_done, 0);
    chk("midreset_error", cfg_error, 0);
    chk("midreset_index", cfg_index, 0);
    @(negedge clk);
    reset_n = 1;
    rel = cyc;
    lat_min = 2; lat_max = 8;
    run(10, -1, 0, -1, 11, 1'b0, 1, 0);
    chk("restart_first_frame", frames.size() > 0 ? frames[0] : 24'h0, 24'h341E00);
    chk("restart_latency", start_cyc.size() > 0 ? start_cyc[0] - rel : -1, 2);

    // Randomized nack/hang patterns against the reference model
    for (int r = 0; r < 6; r++) begin
      ne = $urandom_range(10, 0);
      nt = $urandom_range(5, 0);
      he = ($urandom_range(3, 0) == 0) ? $urandom_range(10, 0) : -1;
      if (he == ne) ne = -1;
      run(20 + r, ne, nt, he, 0, 1'b0, 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/codec_config_seq.md
# codec_config_seq

Register-write sequencer that sits directly upstream of `i2c_controller` and brings up the WM8731 audio codec after reset. It walks a fixed 11-entry register table and drives one 24-bit I2C frame per entry. Each frame is launched with a start pulse and completes when `done` is seen. The sequencer checks `ack`, optionally retries, spaces transfers by a programmable gap, and reports completion and error status to the audio datapath.

## Interface
- `DEV_ADDR`, default 8'h34: codec write address byte, placed in `i2c_data[23:16]`.
- `GAP_CYCLES`, default 16: idle cycles between consecutive frames; 0 is legal (no gap).
- `TIMEOUT_CYCLES`, default 4096: maximum cycles to wait for `done` to rise before the attempt counts as a failure.
- `MAX_RETRIES`, default 3: extra attempts per entry. Used only with `CODEC_CFG_RETRY_EN`.
- `clk` — input — 1: system clock.
- `reset_n` — input — 1: asynchronous, active-low reset.
- `go` — input — 1: one-cycle request to rerun the full table. Honoured only in IDLE.
- `i2c_data` — output — 24: frame to the controller, `{DEV_ADDR, reg[6:0], val[8:0]}`. Registered.
- `start` — output — 1: one-cycle pulse to the controller.
- `done` — input — 1: controller done level.
- `ack` — input — 1: controller ack result; valid while `done` is high.
- `cfg_busy` — output — 1: high while the table is being walked.
- `cfg_done` — output — 1: sticky; high after the last entry, cleared by `go`.
- `cfg_error` — output — 1: sticky; high if any entry finally failed, cleared by `go`.
- `cfg_index` — output — 4: index of the current or last entry, 0..10.

## Operation
- Table, entries 0..10, as `{reg,val}` → `i2c_data`:
  - 0: R15 reset 000 → 341E00
  - 1: R0 017 → 340017
  - 2: R1 017 → 340217
  - 3: R2 079 → 340479
  - 4: R3 079 → 340679
  - 5: R4 012 → 340812
  - 6: R5 000 → 340A00
  - 7: R6 000 → 340C00
  - 8: R7 042 → 340E42
  - 9: R8 000 → 341000
  - 10: R9 001 → 341201
- States and transitions:
  - RESET → LOAD automatically on the first clock after reset release, with index 0.
  - LOAD: latch `i2c_data`, go to START.
  - START: `start`=1 for exactly one cycle, go to WAIT_LO.
  - WAIT_LO: wait for `done`=0, go to WAIT_HI.
  - WAIT_HI: wait for `done`=1, go to CHECK.
  - CHECK: sample `ack`.
    - Success → GAP.
    - Failure → retry or record error (see Configuration).
  - GAP: count `GAP_CYCLES`, then either increment the index and go to LOAD, or go to FINISH if the index is 10.
  - FINISH: set `cfg_done`, go to IDLE.
  - IDLE: `go`=1 clears `cfg_done` and `cfg_error`, sets index 0, goes to LOAD.
- Timeout: one counter covers WAIT_LO plus WAIT_HI. Reaching `TIMEOUT_CYCLES` goes to CHECK with the attempt treated as a failure.
- `cfg_busy` = 1 in every state except IDLE.
- `go` outside IDLE is ignored.
- `i2c_data` stays stable from LOAD until the next LOAD.

## Timing
- Reset values:
  - `start`=0, `i2c_data`=0, `cfg_busy`=1, `cfg_done`=0, `cfg_error`=0, `cfg_index`=0.
  - State RESET; all counters 0.
- `i2c_data` is valid one cycle before and during the `start` pulse.
- The first `start` fires 2 cycles after reset release.
- Back-to-back spacing is at least `GAP_CYCLES`+3 cycles from `done` rising to the next `start`.
- `cfg_done` rises 1 cycle after the GAP of entry 10 ends.
- Deasserting `reset_n` mid-frame aborts immediately to reset values. The sequence restarts at entry 0; no partial state survives.
- `done` already low on entry to WAIT_LO passes through in one cycle.

## Configuration
- `CODEC_CFG_RETRY_EN` defined:
  - On failure, relaunch the same entry via LOAD, up to `MAX_RETRIES` times.
  - The retry counter resets per entry.
  - After the final failure, set `cfg_error` and continue with the next entry.
- Not defined:
  - Any failure sets `cfg_error` and continues with the next entry; no retries.
  - The retry counter logic is absent.

## Test plan
- Reset release, behavioural slave always acking → 11 frames in order 341E00 … 341201; `cfg_done`=1; `cfg_error`=0; `cfg_index`=10.
- Slave nacks entry 3 once, retry enabled → entry 3 sent twice; `cfg_error`=0; 12 `start` pulses total.
- Slave always nacks entry 5, retry enabled with `MAX_RETRIES`=3 → entry 5 sent 4 times, then entry 6 sent; `cfg_error`=1 at the end. Macro off → entry 5 sent once; `cfg_error`=1.
- `done` held low forever at entry 2 with `TIMEOUT_CYCLES`=64 → failure after 64 cycles; `cfg_error`=1; sequence completes.
- `reset_n` pulsed low during entry 4 WAIT_HI → outputs at reset values; restart from 341E00.
- `go` pulsed mid-sequence → ignored. `go` pulsed after `cfg_done` → flags cleared, full table resent.
